// File: rtl/ky11_dma_pkg.sv
// Shared KY11 DMA definitions: Unibus cycle codes, arbiter state encoding and
// the request record latched toward the engine.
package ky11_dma_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        DATI  = 2'd0,
        DATIP = 2'd1,
        DATO  = 2'd2,
        DATOB = 2'd3
    } dma_ctrl_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        dma_ctrl_e         ctrl;
        logic [DATA_W-1:0] wdata;
    } dma_req_t;

endpackage

// File: rtl/ky11_rr_pick.sv
// Rotating-priority picker: grants the first valid requester after ptr,
// wrapping modulo NREQ. Purely combinational.
module ky11_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= NREQ) j = j - NREQ;
        return IW'(j);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        // Scan farthest-first so the nearest valid slot after ptr is left standing.
        for (int k = NREQ; k >= 1; k--) begin
            if (valid[wrap(ptr, k)]) begin
                grant              = '0;
                grant[wrap(ptr, k)] = 1'b1;
                idx                = wrap(ptr, k);
            end
        end
    end

endmodule

// File: rtl/ky11_dma_arb.sv
// Round-robin arbiter sharing the KY11 Unibus DMA engine among NREQ internal
// requesters, with grant hold for DATIP->DATO pairs and ARM dmalock deferral.
module ky11_dma_arb
    import ky11_dma_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LOCKWIN = 16
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     init_in_h,
    input  logic [31:0]              arm_dmalock,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*2-1:0]        req_ctrl,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_done,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_timo,
    output logic                     rsp_perr,
    output logic                     eng_start,
    output logic [ADDR_W-1:0]        eng_addr,
    output logic [1:0]               eng_ctrl,
    output logic [DATA_W-1:0]        eng_wdata,
    input  logic                     eng_done,
    input  logic [DATA_W-1:0]        eng_rdata,
    input  logic                     eng_timo,
    input  logic                     eng_perr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCKWIN) + 1;

    arb_state_e      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic            lock;
    logic            lockreq;
    logic [CW-1:0]   win_cnt;
    dma_req_t        eng_q;
    dma_req_t        sel;
    logic [NREQ-1:0] pick_valid;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            arm_free;

    assign arm_free  = (arm_dmalock == 32'd0);
    assign eng_addr  = eng_q.addr;
    assign eng_ctrl  = eng_q.ctrl;
    assign eng_wdata = eng_q.wdata;

    // While the grant is held, only the current grantee is visible to the picker.
    always_comb begin
        pick_valid = req_valid;
        if (lock) begin
            pick_valid      = '0;
            pick_valid[gnt] = req_valid[gnt];
        end
    end

    ky11_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid (pick_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel.addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel.ctrl  = dma_ctrl_e'(req_ctrl[i*2 +: 2]);
                sel.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ-1);
            gnt       <= '0;
            lock      <= 1'b0;
            lockreq   <= 1'b0;
            win_cnt   <= '0;
            eng_q     <= '0;
            eng_start <= 1'b0;
            req_ack   <= '0;
            rsp_done  <= '0;
            rsp_rdata <= '0;
            rsp_timo  <= 1'b0;
            rsp_perr  <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            req_ack   <= '0;
            rsp_done  <= '0;
            case (state)
                IDLE: begin
                    if (!init_in_h && (req_valid != '0) && arm_free)
                        state <= PICK;
                end
                PICK: begin
                    if (init_in_h || (pick_valid == '0)) begin
                        lock  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ptr       <= pick_idx;
                        gnt       <= pick_idx;
                        eng_q     <= sel;
                        lockreq   <= req_lock[pick_idx];
                        eng_start <= 1'b1;
                        req_ack   <= pick_grant;
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (init_in_h) begin
                        // Aborted cycle still completes toward the grantee, flagged as timeout.
                        rsp_done[gnt] <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_timo      <= 1'b1;
                        rsp_perr      <= 1'b0;
                        lockreq       <= 1'b0;
                        lock          <= 1'b0;
                        state         <= DONE;
                    end else if (state == ISSUE) begin
                        state <= WAIT;
                    end else if (eng_done) begin
                        rsp_done[gnt] <= 1'b1;
                        rsp_rdata     <= eng_rdata;
                        rsp_timo      <= eng_timo;
                        rsp_perr      <= eng_perr;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (lockreq && !rsp_timo) begin
                        lock    <= 1'b1;
                        win_cnt <= '0;
                        state   <= HOLD;
                    end else begin
                        lock  <= 1'b0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (init_in_h) begin
                        lock  <= 1'b0;
                        state <= IDLE;
                    end else if (req_valid[gnt] && arm_free) begin
                        state <= PICK;
                    end else if (win_cnt == CW'(LOCKWIN-1)) begin
                        lock  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A requester may only drop req_valid once its ack has been seen.
    logic [NREQ-1:0] pend_q;
    always_ff @(posedge CLOCK) begin
        if (RESET) pend_q <= '0;
        else       pend_q <= req_valid & ~req_ack;
    end
    always_ff @(posedge CLOCK) begin
        if (!RESET) assert ((pend_q & ~req_valid & ~req_ack) == '0);
    end
`endif

endmodule
